// File: rtl/systolic_pkg.sv
// Shared bank-select encodings and statistics-counter helpers for the
// systolic array memory responder.
package systolic_pkg;

    localparam logic [1:0] SEL_A       = 2'd0;
    localparam logic [1:0] SEL_B       = 2'd1;
    localparam logic [1:0] SEL_C       = 2'd2;
    localparam logic [1:0] SEL_ILLEGAL = 2'd3;

    localparam int CNT_W = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/systolic_mem_responder_rsp_fifo.sv
// Two-entry first-word-fall-through response FIFO; head data reads as zero when empty.
module rsp_fifo #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         valid,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && (count != 2'd2);
    assign valid   = (count != 2'd0);
    assign rdata   = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/systolic_mem_responder.sv
// A/B/C bank responder: controller reads A/B and writes C with priority,
// host preloads A/B and reads back C through a stalled valid/ready port.
module systolic_mem_responder
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ACCUM_WIDTH = 32,
    parameter int ADDR_WIDTH  = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_WIDTH-1:0]  mem_addr_a,
    input  logic                   mem_read_en_a,
    output logic [DATA_WIDTH-1:0]  mem_data_a,
    input  logic [ADDR_WIDTH-1:0]  mem_addr_b,
    input  logic                   mem_read_en_b,
    output logic [DATA_WIDTH-1:0]  mem_data_b,
    input  logic [ADDR_WIDTH-1:0]  mem_addr_c,
    input  logic                   mem_write_en_c,
    input  logic [ACCUM_WIDTH-1:0] mem_data_c,
    input  logic                   host_req_valid,
    output logic                   host_req_ready,
    input  logic                   host_req_write,
    input  logic [1:0]             host_req_sel,
    input  logic [ADDR_WIDTH-1:0]  host_req_addr,
    input  logic [ACCUM_WIDTH-1:0] host_req_wdata,
    output logic                   host_rsp_valid,
    input  logic                   host_rsp_ready,
    output logic [ACCUM_WIDTH-1:0] host_rsp_rdata,
    output logic                   host_rsp_err,
    input  logic                   stat_clear,
    output logic [CNT_W-1:0]       conflict_count,
    output logic [CNT_W-1:0]       c_write_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]  bank_a [DEPTH];
    logic [DATA_WIDTH-1:0]  bank_b [DEPTH];
    logic [ACCUM_WIDTH-1:0] bank_c [DEPTH];

    logic                   sel_busy, accept, host_wr, host_rd;
    logic [1:0]             fifo_count, occ;
    logic                   inflight;
    logic [1:0]             rsp_sel_q;
    logic [DATA_WIDTH-1:0]  rd_a_q, rd_b_q, hold_a, hold_b;
    logic [ACCUM_WIDTH-1:0] rd_c_q;
    logic                   ctrl_a_q, ctrl_b_q;
    logic [ACCUM_WIDTH:0]   push_word;
    logic [ADDR_WIDTH-1:0]  raddr_a, raddr_b, waddr_c;
    logic [ACCUM_WIDTH-1:0] wdata_c;
    logic                   rd_en_a, rd_en_b, rd_en_c, we_c;

    always_comb begin
        sel_busy = 1'b0;
        case (host_req_sel)
            SEL_A:   sel_busy = mem_read_en_a;
            SEL_B:   sel_busy = mem_read_en_b;
            SEL_C:   sel_busy = mem_write_en_c;
            default: sel_busy = 1'b0;
        endcase
    end

    assign occ            = fifo_count + {1'b0, inflight};
    assign host_req_ready = !sel_busy && (host_req_write || (occ < 2'd2));
    assign accept         = host_req_valid && host_req_ready;
    assign host_wr        = accept && host_req_write;
    assign host_rd        = accept && !host_req_write;

    // The host only reaches a bank the controller is not using, so one
    // address mux per bank keeps every bank single-ported.
    assign raddr_a = mem_read_en_a ? mem_addr_a : host_req_addr;
    assign raddr_b = mem_read_en_b ? mem_addr_b : host_req_addr;
    assign rd_en_a = mem_read_en_a || (host_rd && host_req_sel == SEL_A);
    assign rd_en_b = mem_read_en_b || (host_rd && host_req_sel == SEL_B);
    assign rd_en_c = host_rd && host_req_sel == SEL_C;
    assign we_c    = mem_write_en_c || (host_wr && host_req_sel == SEL_C);
    assign waddr_c = mem_write_en_c ? mem_addr_c : host_req_addr;
    assign wdata_c = mem_write_en_c ? mem_data_c : host_req_wdata;

    always_ff @(posedge clk) begin
        if (host_wr && host_req_sel == SEL_A) bank_a[host_req_addr] <= host_req_wdata[DATA_WIDTH-1:0];
        if (host_wr && host_req_sel == SEL_B) bank_b[host_req_addr] <= host_req_wdata[DATA_WIDTH-1:0];
        if (we_c) bank_c[waddr_c] <= wdata_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
            rd_c_q <= '0;
        end else begin
            if (rd_en_a) rd_a_q <= bank_a[raddr_a];
            if (rd_en_b) rd_b_q <= bank_b[raddr_b];
            if (rd_en_c) rd_c_q <= bank_c[host_req_addr];
        end
    end

    // The bank output register is shared with host reads, so the controller
    // view falls back to a hold copy whenever it did not read last cycle.
    assign mem_data_a = ctrl_a_q ? rd_a_q : hold_a;
    assign mem_data_b = ctrl_b_q ? rd_b_q : hold_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_a_q       <= 1'b0;
            ctrl_b_q       <= 1'b0;
            hold_a         <= '0;
            hold_b         <= '0;
            inflight       <= 1'b0;
            rsp_sel_q      <= SEL_A;
            conflict_count <= '0;
            c_write_count  <= '0;
        end else begin
            ctrl_a_q <= mem_read_en_a;
            ctrl_b_q <= mem_read_en_b;
            hold_a   <= mem_data_a;
            hold_b   <= mem_data_b;
            inflight <= host_rd;
            if (host_rd) rsp_sel_q <= host_req_sel;
            if (stat_clear)                      conflict_count <= '0;
            else if (host_req_valid && sel_busy) conflict_count <= sat_inc(conflict_count);
            if (stat_clear)          c_write_count <= '0;
            else if (mem_write_en_c) c_write_count <= sat_inc(c_write_count);
        end
    end

    always_comb begin
        push_word = '0;
        case (rsp_sel_q)
            SEL_A:   push_word = {1'b0, ACCUM_WIDTH'(rd_a_q)};
            SEL_B:   push_word = {1'b0, ACCUM_WIDTH'(rd_b_q)};
            SEL_C:   push_word = {1'b0, rd_c_q};
            default: push_word = {1'b1, {ACCUM_WIDTH{1'b0}}};
        endcase
    end

    rsp_fifo #(.W(ACCUM_WIDTH + 1)) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .wdata (push_word),
        .pop   (host_rsp_valid && host_rsp_ready),
        .rdata ({host_rsp_err, host_rsp_rdata}),
        .valid (host_rsp_valid),
        .count (fifo_count)
    );

endmodule
